mem_arbiter_fsm: RTL and testbench

//  Registered arbiter/sequencer sharing one RAM port between the instruction fetch

---
 rtl/mem_arbiter_fsm.sv | 120 ++++++++++++
 tb/tb_mem_arbiter_fsm.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_fsm.sv
// Arbiter/sequencer sharing one RAM port between instruction fetch and data access.
// Optional instruction anti-starvation guard: define ARB_STARVE_GUARD_EN.
module mem_arbiter_fsm #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  output logic              ierr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              derr,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              igrant,
  output logic              dgrant
);

  typedef enum logic [1:0] {IDLE, ISERV, DSERV} state_t;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  state_t state, state_nxt;
  logic   d_req, done, fault, i_first;

  assign d_req = dREN | dWEN;
  assign done  = (ramstate == RS_ACCESS) || (ramstate == RS_ERROR);
  assign fault = (ramstate == RS_ERROR);

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);
  logic [CW-1:0] starve_cnt;

  // Counts data completions that an instruction request had to sit through.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      starve_cnt <= '0;
    else if (state == DSERV && d_req && done && iREN && starve_cnt != CNT_MAX)
      starve_cnt <= starve_cnt + 1'b1;
    else if ((state == ISERV && iREN && done) || (state == IDLE && !iREN))
      starve_cnt <= '0;
  end

  assign i_first = iREN && (starve_cnt == CNT_MAX);
`else
  assign i_first = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    iwait     = 1'b1;
    dwait     = 1'b1;
    ierr      = 1'b0;
    derr      = 1'b0;
    case (state)
      IDLE: begin
        if (i_first)    state_nxt = ISERV;
        else if (d_req) state_nxt = DSERV;
        else if (iREN)  state_nxt = ISERV;
      end
      DSERV: begin
        // A dropped request aborts the transfer without a completion pulse.
        if (!d_req) state_nxt = IDLE;
        else begin
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (done) begin
            dwait     = 1'b0;
            derr      = fault;
            state_nxt = IDLE;
          end
        end
      end
      ISERV: begin
        if (!iREN) state_nxt = IDLE;
        else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (done) begin
            iwait     = 1'b0;
            ierr      = fault;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign iload  = ramload;
  assign dload  = ramload;
  assign igrant = (state == ISERV);
  assign dgrant = (state == DSERV);

endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// Scoreboard bench for mem_arbiter_fsm: stimulus queues expected completions,
// a negedge monitor pops and compares each completion the DUT presents.
module tb_mem_arbiter_fsm;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic CLK = 1'b0, RST = 1'b1;
  logic iREN = 0, dREN = 0, dWEN = 0;
  logic [AW-1:0] iaddr = '0, daddr = '0;
  logic [DW-1:0] dstore = '0, ramload = '0;
  logic [1:0] ramstate = FREE;
  logic iwait, ierr, dwait, derr, ramREN, ramWEN, igrant, dgrant;
  logic [DW-1:0] iload, dload, ramstore;
  logic [AW-1:0] ramaddr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_d;
    logic [31:0] load;
    bit          err;
  } cmp_t;
  cmp_t sb[$];

  always #5 CLK = ~CLK;

  mem_arbiter_fsm #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload), .ierr(ierr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload), .derr(derr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .igrant(igrant), .dgrant(dgrant)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit is_d, input logic [31:0] load, input bit err);
    cmp_t e;
    e.is_d = is_d; e.load = load; e.err = err;
    sb.push_back(e);
  endtask

  task automatic nxt; @(posedge CLK); #1; endtask
  task automatic smp; @(negedge CLK); endtask

  // Monitor: every completion must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (!RST) begin
      if (!iwait || !dwait) begin
        cmp_t e;
        check("both_waits_low", {62'd0, iwait, dwait} == 64'd0, 64'd0);
        if (sb.size() == 0) begin
          check("unexpected_completion", {iwait, dwait}, 2'b11);
        end else begin
          e = sb.pop_front();
          check("completion_path", {63'd0, !dwait}, {63'd0, e.is_d});
          check("completion_load", !dwait ? dload : iload, e.load);
          check("completion_err", {derr, ierr}, e.is_d ? {e.err, 1'b0} : {1'b0, e.err});
        end
      end else begin
        check("err_without_done", {ierr, derr}, 2'b00);
      end
    end
  end

  initial begin
    // Reset state
    nxt; smp;
    check("rst_waits", {iwait, dwait}, 2'b11);
    check("rst_grants", {igrant, dgrant}, 2'b00);
    check("rst_ram_en", {ramREN, ramWEN}, 2'b00);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_ramstore", ramstore, 0);
    nxt; RST = 0;

    // Instruction read: BUSY x2 then ACCESS
    iREN = 1; iaddr = 32'h40; ramstate = BUSY; smp;
    check("t2_idle_ren", ramREN, 0);
    nxt; smp;
    check("t2_c1_ren", ramREN, 1);
    check("t2_c1_addr", ramaddr, 32'h40);
    check("t2_c1_igrant", igrant, 1);
    nxt; smp;
    check("t2_c2_iwait", iwait, 1);
    nxt; ramstate = ACCESS; ramload = 32'hDEADBEEF; push(0, 32'hDEADBEEF, 0); smp;
    nxt; iREN = 0; ramstate = FREE; smp;
    check("t2_igrant_after", igrant, 0);

    // Simultaneous requests: data wins, then instruction
    nxt; iREN = 1; dREN = 1; daddr = 32'h10; ramstate = ACCESS; ramload = 32'h11111111;
    push(1, 32'h11111111, 0); push(0, 32'h22222222, 0); smp;
    nxt; smp;
    check("t3_c1_dgrant", dgrant, 1);
    nxt; dREN = 0; ramload = 32'h22222222; smp;
    check("t3_c2_idle", {igrant, dgrant, iwait, dwait}, 4'b0011);
    nxt; smp;
    check("t3_c3_igrant", igrant, 1);
    nxt; iREN = 0; ramstate = FREE; smp;

    // Write wins over read, ERROR response
    nxt; dWEN = 1; dREN = 1; daddr = 32'h80; dstore = 32'h1234; ramstate = ERROR; ramload = 0;
    push(1, 32'h0, 1); smp;
    nxt; smp;
    check("t4_wen_ren", {ramWEN, ramREN}, 2'b10);
    check("t4_addr", ramaddr, 32'h80);
    check("t4_store", ramstore, 32'h1234);
    nxt; dWEN = 0; dREN = 0; ramstate = FREE; smp;
    check("t4_derr_gone", {derr, dwait}, 2'b01);

    // Abort: drop dREN during BUSY
    nxt; dREN = 1; daddr = 32'h44; ramstate = BUSY; smp;
    nxt; smp;
    check("t5_c1_ren", ramREN, 1);
    nxt; dREN = 0; smp;
    check("t5_abort_ren", ramREN, 0);
    check("t5_abort_dwait", dwait, 1);
    nxt; smp;
    check("t5_idle", dgrant, 0);

    // Reset mid-transfer
    nxt; dWEN = 1; daddr = 32'h8; dstore = 32'h55; ramstate = BUSY; smp;
    nxt; smp;
    check("t1_wen_before", ramWEN, 1);
    nxt; RST = 1; #1;
    check("t1_rst_wen", ramWEN, 0);
    check("t1_rst_dwait", dwait, 1);
    check("t1_rst_dgrant", dgrant, 0);
    smp;
    nxt; RST = 0; dWEN = 0; ramstate = FREE; smp;
    check("t1_post_idle", {igrant, dgrant}, 2'b00);

    // Both held with ACCESS: data completes on odd cycles
    nxt; dREN = 1; iREN = 1; ramstate = ACCESS; ramload = 32'hCAFE0000;
`ifdef ARB_STARVE_GUARD_EN
    for (int k = 0; k < 6; k++) push(k != 4, 32'hCAFE0000, 0);
`else
    for (int k = 0; k < 6; k++) push(1, 32'hCAFE0000, 0);
`endif
    for (int c = 1; c <= 12; c++) nxt;
    dREN = 0; iREN = 0; ramstate = FREE;
    nxt; nxt; smp;
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, expected finish before 100000");
    $fatal(1);
  end
endmodule
